// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire layer.
`timescale 1ns/1ps
package lif_pkg;

    typedef enum logic {
        RESET_SUBTRACT = 1'b0,
        RESET_ZERO     = 1'b1
    } reset_mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int SAT_W = 64;

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x,
                                                         input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/lif_core.sv
// Combinational single-neuron update: leak, integrate, fire, refractory hold.
`timescale 1ns/1ps
module lif_core
    import lif_pkg::*;
#(
    parameter int CUR_W    = 8,
    parameter int MEM_W    = 16,
    parameter int BETA_W   = 8,
    parameter int REFRAC_W = 4
) (
    input  logic signed [MEM_W-1:0]  mem,
    input  logic [REFRAC_W-1:0]      refrac,
    input  logic signed [CUR_W-1:0]  current,
    input  logic signed [MEM_W-1:0]  threshold,
    input  logic [BETA_W-1:0]        beta,
    input  logic [REFRAC_W-1:0]      refractory,
    input  reset_mode_e              reset_mode,
    output logic signed [MEM_W-1:0]  next_mem,
    output logic [REFRAC_W-1:0]      next_refrac,
    output logic                     spike
);

    localparam int PROD_W = MEM_W + BETA_W + 1;

    logic signed [PROD_W-1:0] mem_x;
    logic signed [PROD_W-1:0] beta_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [SAT_W-1:0]  prod_w;
    logic signed [SAT_W-1:0]  decay_w;
    logic signed [SAT_W-1:0]  cur_w;
    logic signed [SAT_W-1:0]  thr_w;
    logic signed [SAT_W-1:0]  integ_w;
    logic signed [MEM_W-1:0]  integ;
    logic signed [MEM_W-1:0]  sub_m;

    always_comb begin
        mem_x   = {{(BETA_W + 1){mem[MEM_W-1]}}, mem};
        beta_x  = {{(MEM_W + 1){1'b0}}, beta};
        prod    = mem_x * beta_x;
        // Widen before the arithmetic shift so the leak rounds toward -inf.
        prod_w  = {{(SAT_W - PROD_W){prod[PROD_W-1]}}, prod};
        decay_w = prod_w >>> (BETA_W - 1);
        cur_w   = {{(SAT_W - CUR_W){current[CUR_W-1]}}, current};
        thr_w   = {{(SAT_W - MEM_W){threshold[MEM_W-1]}}, threshold};
        integ_w = saturate(decay_w + cur_w, MEM_W);
        integ   = MEM_W'(integ_w);
        sub_m   = MEM_W'(saturate(integ_w - thr_w, MEM_W));

        next_mem    = '0;
        next_refrac = '0;
        spike       = 1'b0;
        if (refrac != '0) begin
            next_refrac = refrac - 1'b1;
        end else if (integ >= threshold) begin
            spike       = 1'b1;
            next_refrac = refractory;
            next_mem    = (reset_mode == RESET_ZERO) ? '0 : sub_m;
        end else begin
            next_mem = integ;
        end
    end

endmodule

// File: rtl/lif_layer.sv
// Time-multiplexed layer of LIF neurons: per-neuron state arrays around one lif_core.
`timescale 1ns/1ps
module lif_layer
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int CUR_W       = 8,
    parameter int MEM_W       = 16,
    parameter int BETA_W      = 8,
    parameter int REFRAC_W    = 4,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [MEM_W-1:0]  cfg_threshold,
    input  logic [BETA_W-1:0]        cfg_beta,
    input  logic [REFRAC_W-1:0]      cfg_refractory,
    input  logic                     cfg_reset_mode,
    input  logic                     clear_req,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [CUR_W-1:0]  in_current,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_spike,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic signed [MEM_W-1:0]  out_mem,
    output logic [IDX_W:0]           out_count,
    output logic                     busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_e                  state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        clr_idx;
    logic [IDX_W:0]          spike_acc;
    logic signed [MEM_W-1:0] mem_arr    [NUM_NEURONS];
    logic [REFRAC_W-1:0]     refrac_arr [NUM_NEURONS];

    logic signed [MEM_W-1:0] thr_q;
    logic [BETA_W-1:0]       beta_q;
    logic [REFRAC_W-1:0]     refr_q;
    reset_mode_e             mode_q;

    logic                    first_beat;
    logic                    accept;
    logic signed [MEM_W-1:0] thr_e;
    logic [BETA_W-1:0]       beta_e;
    logic [REFRAC_W-1:0]     refr_e;
    reset_mode_e             mode_e;
    logic signed [MEM_W-1:0] core_mem;
    logic [REFRAC_W-1:0]     core_refrac;
    logic                    core_spike;
    logic [IDX_W:0]          cnt_next;

    // Handshake: a beat transfers on in_valid & in_ready; a result transfers on
    // out_valid & out_ready, and out_* hold stable while out_valid & !out_ready.
    // A clear request wins over a same-cycle beat, so in_ready drops with it.
    assign busy       = (state == ST_CLEAR);
    assign in_ready   = (state == ST_RUN) & ~clear_req & (~out_valid | out_ready);
    assign accept     = in_valid & in_ready;
    assign first_beat = (idx == '0);

    // The index-0 beat uses live config; the rest of the timestep uses the latched copy.
    assign thr_e  = first_beat ? cfg_threshold : thr_q;
    assign beta_e = first_beat ? cfg_beta : beta_q;
    assign refr_e = first_beat ? cfg_refractory : refr_q;
    assign mode_e = first_beat ? reset_mode_e'(cfg_reset_mode) : mode_q;

    assign cnt_next = (first_beat ? '0 : spike_acc) + {{IDX_W{1'b0}}, core_spike};

    lif_core #(
        .CUR_W    (CUR_W),
        .MEM_W    (MEM_W),
        .BETA_W   (BETA_W),
        .REFRAC_W (REFRAC_W)
    ) u_core (
        .mem         (mem_arr[idx]),
        .refrac      (refrac_arr[idx]),
        .current     (in_current),
        .threshold   (thr_e),
        .beta        (beta_e),
        .refractory  (refr_e),
        .reset_mode  (mode_e),
        .next_mem    (core_mem),
        .next_refrac (core_refrac),
        .spike       (core_spike)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            idx       <= '0;
            clr_idx   <= '0;
            spike_acc <= '0;
            thr_q     <= '0;
            beta_q    <= '0;
            refr_q    <= '0;
            mode_q    <= RESET_SUBTRACT;
            out_valid <= 1'b0;
            out_spike <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_mem   <= '0;
            out_count <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mem_arr[i]    <= '0;
                refrac_arr[i] <= '0;
            end
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_spike <= core_spike;
                out_index <= idx;
                out_last  <= (idx == LAST_IDX);
                out_mem   <= core_mem;
                out_count <= cnt_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (clear_req) begin
                        state   <= ST_CLEAR;
                        clr_idx <= '0;
                    end else if (accept) begin
                        mem_arr[idx]    <= core_mem;
                        refrac_arr[idx] <= core_refrac;
                        spike_acc       <= cnt_next;
                        idx             <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                        if (first_beat) begin
                            thr_q  <= cfg_threshold;
                            beta_q <= cfg_beta;
                            refr_q <= cfg_refractory;
                            mode_q <= reset_mode_e'(cfg_reset_mode);
                        end
                    end
                end
                ST_CLEAR: begin
                    mem_arr[clr_idx]    <= '0;
                    refrac_arr[clr_idx] <= '0;
                    if (clr_idx == LAST_IDX) begin
                        state     <= ST_RUN;
                        idx       <= '0;
                        spike_acc <= '0;
                        clr_idx   <= '0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_layer.sv
// Directed bench for lif_layer with four neurons and hand-computed expectations.
`timescale 1ns/1ps
module tb_lif_layer;

    localparam int N        = 4;
    localparam int CUR_W    = 8;
    localparam int MEM_W    = 16;
    localparam int BETA_W   = 8;
    localparam int REFRAC_W = 4;
    localparam int IDX_W    = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic signed [MEM_W-1:0] cfg_threshold;
    logic [BETA_W-1:0]       cfg_beta;
    logic [REFRAC_W-1:0]     cfg_refractory;
    logic                    cfg_reset_mode;
    logic                    clear_req;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [CUR_W-1:0] in_current;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_spike;
    logic [IDX_W-1:0]        out_index;
    logic                    out_last;
    logic signed [MEM_W-1:0] out_mem;
    logic [IDX_W:0]          out_count;
    logic                    busy;

    lif_layer #(
        .NUM_NEURONS (N),
        .CUR_W       (CUR_W),
        .MEM_W       (MEM_W),
        .BETA_W      (BETA_W),
        .REFRAC_W    (REFRAC_W),
        .IDX_W       (IDX_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_threshold  (cfg_threshold),
        .cfg_beta       (cfg_beta),
        .cfg_refractory (cfg_refractory),
        .cfg_reset_mode (cfg_reset_mode),
        .clear_req      (clear_req),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_current     (in_current),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_spike      (out_spike),
        .out_index      (out_index),
        .out_last       (out_last),
        .out_mem        (out_mem),
        .out_count      (out_count),
        .busy           (busy)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [31:0] r_spike [N];
    logic signed [31:0] r_mem   [N];
    logic signed [31:0] r_idx   [N];
    logic signed [31:0] r_last  [N];
    logic signed [31:0] r_count [N];

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_current     = '0;
        clear_req      = 1'b0;
        out_ready      = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_cfg(input int thr, input int beta, input int refr, input int mode);
        cfg_threshold  = MEM_W'(thr);
        cfg_beta       = BETA_W'(beta);
        cfg_refractory = REFRAC_W'(refr);
        cfg_reset_mode = mode[0];
    endtask

    // Drive one beat, wait (bounded) for acceptance, capture the registered result.
    task automatic send_beat(input int slot, input int cur);
        int waited;
        @(negedge clk);
        in_valid   = 1'b1;
        in_current = CUR_W'(cur);
        waited     = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("out_valid", out_valid, 1);
        r_spike[slot] = out_spike;
        r_mem[slot]   = out_mem;
        r_idx[slot]   = out_index;
        r_last[slot]  = out_last;
        r_count[slot] = out_count;
    endtask

    task automatic run_step(input int c0, input int c1, input int c2, input int c3);
        send_beat(0, c0);
        send_beat(1, c1);
        send_beat(2, c2);
        send_beat(3, c3);
        for (int i = 0; i < N; i++) begin
            check("index", r_idx[i], i);
            check("last", r_last[i], (i == N - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1_mem[3]   = '{120, 180, 10};
        int e1_spk[3]   = '{0, 0, 1};
        int e2_mem[6]   = '{120, 180, 0, 0, 0, 120};
        int e2_spk[6]   = '{0, 0, 1, 0, 0, 0};
        int exp_sat;
        int busy_cycles;
        logic seen_valid;

        // Reset values
        set_cfg(200, 64, 0, 0);
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_spike", out_spike, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_mem", out_mem, 0);
        check("rst_out_count", out_count, 0);

        // Subtract-threshold reset, no refractory
        for (int s = 0; s < 3; s++) begin
            run_step(120, 0, 0, 0);
            check("t1_mem0", r_mem[0], e1_mem[s]);
            check("t1_spk0", r_spike[0], e1_spk[s]);
            check("t1_count", r_count[N-1], e1_spk[s]);
            check("t1_mem3", r_mem[3], 0);
        end

        // Reset-to-zero with two refractory steps
        set_cfg(200, 64, 2, 1);
        do_reset();
        for (int s = 0; s < 6; s++) begin
            run_step(120, 0, 0, 0);
            check("t2_mem0", r_mem[0], e2_mem[s]);
            check("t2_spk0", r_spike[0], e2_spk[s]);
            check("t2_count", r_count[N-1], e2_spk[s]);
        end

        // Negative saturation with beta = 1.0
        set_cfg(200, 128, 0, 0);
        do_reset();
        for (int k = 1; k <= 260; k++) begin
            run_step(-128, -128, -128, -128);
            exp_sat = -128 * k;
            if (exp_sat < -32768) exp_sat = -32768;
            check("t3_mem0", r_mem[0], exp_sat);
            check("t3_mem3", r_mem[3], exp_sat);
            check("t3_count", r_count[N-1], 0);
        end

        // Backpressure mid-timestep
        set_cfg(200, 64, 0, 0);
        do_reset();
        send_beat(0, 120);
        send_beat(1, 50);
        check("bp_mem1", r_mem[1], 50);
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_current = '0;
        #1;
        check("bp_in_ready0", in_ready, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_index", out_index, 1);
            check("bp_mem", out_mem, 50);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_index", out_index, 2);
        check("bp_next_mem", out_mem, 0);
        send_beat(3, 0);
        check("bp_idx3", r_idx[3], 3);
        check("bp_last3", r_last[3], 1);
        send_beat(0, 120);
        check("bp_wrap_idx", r_idx[0], 0);
        check("bp_wrap_mem0", r_mem[0], 180);
        send_beat(1, 0);
        check("bp_wrap_mem1", r_mem[1], 25);

        // Bulk clear mid-timestep
        do_reset();
        send_beat(0, 120);
        send_beat(1, 30);
        send_beat(2, 40);
        @(negedge clk);
        clear_req  = 1'b1;
        in_valid   = 1'b1;
        in_current = 8'sd5;
        #1;
        check("clr_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        in_valid  = 1'b0;
        check("clr_busy", busy, 1);
        busy_cycles = 0;
        seen_valid  = out_valid;
        while (busy && busy_cycles < 20) begin
            busy_cycles++;
            @(posedge clk);
            #1;
            seen_valid = seen_valid | out_valid;
        end
        check("clr_busy_cycles", busy_cycles, N);
        check("clr_no_output", seen_valid, 0);
        check("clr_ready_after", in_ready, 1);
        run_step(0, 0, 0, 0);
        check("clr_mem0", r_mem[0], 0);
        check("clr_mem1", r_mem[1], 0);
        check("clr_mem2", r_mem[2], 0);
        check("clr_mem3", r_mem[3], 0);
        run_step(120, 0, 0, 0);
        check("clr_mem0_after", r_mem[0], 120);

        // Threshold change mid-timestep applies from the next index 0
        set_cfg(200, 64, 0, 0);
        do_reset();
        send_beat(0, 120);
        send_beat(1, 120);
        cfg_threshold = 16'sd100;
        send_beat(2, 120);
        send_beat(3, 0);
        check("cfg_spk2", r_spike[2], 0);
        check("cfg_mem2", r_mem[2], 120);
        check("cfg_count1", r_count[N-1], 0);
        run_step(120, 0, 0, 0);
        check("cfg_spk0", r_spike[0], 1);
        check("cfg_mem0", r_mem[0], 80);
        check("cfg_mem1", r_mem[1], 60);
        check("cfg_spk1", r_spike[1], 0);
        check("cfg_count2", r_count[N-1], 1);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
